// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared sizes, state/status encodings and grid addressing for the sweep engine.
package sudoku_pkg;
    localparam int BOX = 3;
    localparam int D = BOX * BOX;
    localparam int CELLS = D * D;
    typedef logic [D-1:0] cand_t;
    typedef enum logic [1:0] {IDLE, SCAN, CHECK, DONE} scan_state_t;
    typedef enum logic [1:0] {SOLVED, STALLED, CONTRADICTION, TIMEOUT} scan_status_t;
    function automatic int cell_off(input int r, input int c, input int n);
        return (r * n + c) * n;
    endfunction
endpackage

// File: rtl/sudoku_sweep_engine_box_update.sv
// sweep_box_update: combinational elimination for one box; hidden singles when SUDOKU_SWEEP_HIDDEN_SINGLE_EN is defined.
module sweep_box_update #(
    parameter int BOX = 3,
    localparam int N = BOX * BOX
) (
    input  logic [N*N-1:0]   cells,
    input  logic [BOX*N-1:0] row_agg,
    input  logic [BOX*N-1:0] col_agg,
    input  logic [N-1:0]     box_agg,
    output logic [N*N-1:0]   cells_new,
    output logic             changed
);
    logic [N*N-1:0] elim;
    // An unsolved cell never contributes to the solved aggregates, so no self-exclusion is needed.
    always_comb begin
        elim = '0;
        for (int i = 0; i < N; i++)
            elim[i*N +: N] = $onehot(cells[i*N +: N]) ? cells[i*N +: N] :
                cells[i*N +: N] & ~(row_agg[(i/BOX)*N +: N] | col_agg[(i%BOX)*N +: N] | box_agg);
    end
`ifdef SUDOKU_SWEEP_HIDDEN_SINGLE_EN
    logic [N*N-1:0] open_m;
    logic [N-1:0] seen1, seen2, sole, force_m;
    always_comb begin
        open_m = '0;
        seen1 = '0;
        seen2 = '0;
        for (int i = 0; i < N; i++) begin
            open_m[i*N +: N] = $onehot(elim[i*N +: N]) ? '0 : elim[i*N +: N];
            seen2 = seen2 | (seen1 & open_m[i*N +: N]);
            seen1 = seen1 | open_m[i*N +: N];
        end
        sole = seen1 & ~seen2;
        cells_new = elim;
        force_m = '0;
        for (int i = 0; i < N; i++) begin
            force_m = open_m[i*N +: N] & sole;
            cells_new[i*N +: N] = force_m == '0 ? elim[i*N +: N] : ($onehot(force_m) ? force_m : '0);
        end
    end
`else
    assign cells_new = elim;
`endif
    assign changed = cells_new != cells;
endmodule

// File: rtl/sudoku_sweep_engine.sv
// sudoku_sweep_engine: repeats box-by-box candidate elimination sweeps until solved, stalled, contradicted or timed out.
// Hidden-single forcing is enabled by defining SUDOKU_SWEEP_HIDDEN_SINGLE_EN.
module sudoku_sweep_engine
    import sudoku_pkg::*;
#(
    parameter int BOX = 3,
    parameter int MAX_SWEEPS = 32,
    localparam int N = BOX * BOX,
    localparam int BW = $clog2(N),
    localparam int SW = $clog2(MAX_SWEEPS + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [N*N*N-1:0] i_Grid,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [1:0]       o_Status,
    output logic [SW-1:0]    o_Sweeps,
    output logic [N*N*N-1:0] o_Grid
);
    scan_state_t state, state_n;
    scan_status_t res;
    logic term, chg, changed, last_box, any_zero, all_one;
    logic [BW-1:0] box_idx;
    logic [N*N-1:0] row_or, col_or, box_or, box_cells, box_new;
    logic [BOX*N-1:0] row_sel, col_sel;
    logic [N-1:0] box_sel;
    int br, bc;

    assign o_Busy = state != IDLE;
    assign o_Done = state == DONE;
    assign last_box = box_idx == BW'(N - 1);
    assign br = int'(box_idx) / BOX;
    assign bc = int'(box_idx) % BOX;
    assign box_sel = box_or[int'(box_idx)*N +: N];

    // Solved-digit aggregates per row/column/box plus whole-grid terminal conditions.
    always_comb begin
        row_or = '0;
        col_or = '0;
        box_or = '0;
        any_zero = 1'b0;
        all_one = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if ($onehot(o_Grid[cell_off(r, c, N) +: N])) begin
                    row_or[r*N +: N] = row_or[r*N +: N] | o_Grid[cell_off(r, c, N) +: N];
                    col_or[c*N +: N] = col_or[c*N +: N] | o_Grid[cell_off(r, c, N) +: N];
                    box_or[((r/BOX)*BOX + c/BOX)*N +: N] = box_or[((r/BOX)*BOX + c/BOX)*N +: N] | o_Grid[cell_off(r, c, N) +: N];
                end else
                    all_one = 1'b0;
                if (o_Grid[cell_off(r, c, N) +: N] == '0)
                    any_zero = 1'b1;
            end
    end

    always_comb begin
        box_cells = '0;
        row_sel = '0;
        col_sel = '0;
        for (int i = 0; i < N; i++)
            box_cells[i*N +: N] = o_Grid[cell_off(br*BOX + i/BOX, bc*BOX + i%BOX, N) +: N];
        for (int i = 0; i < BOX; i++) begin
            row_sel[i*N +: N] = row_or[(br*BOX + i)*N +: N];
            col_sel[i*N +: N] = col_or[(bc*BOX + i)*N +: N];
        end
    end

    sweep_box_update #(.BOX(BOX)) u_box (
        .cells    (box_cells),
        .row_agg  (row_sel),
        .col_agg  (col_sel),
        .box_agg  (box_sel),
        .cells_new(box_new),
        .changed  (changed)
    );

    always_comb begin
        state_n = state;
        term = 1'b0;
        res = SOLVED;
        case (state)
            IDLE:  state_n = i_Start ? SCAN : IDLE;
            SCAN:  state_n = last_box ? CHECK : SCAN;
            CHECK: begin
                term = any_zero || all_one || !chg || o_Sweeps == SW'(MAX_SWEEPS);
                res = any_zero ? CONTRADICTION : all_one ? SOLVED : !chg ? STALLED : TIMEOUT;
                state_n = term ? DONE : SCAN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
            o_Status <= 2'd0;
            o_Sweeps <= '0;
            o_Grid <= '0;
            box_idx <= '0;
            chg <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (i_Start) begin
                    o_Grid <= i_Grid;
                    o_Sweeps <= '0;
                    chg <= 1'b0;
                    box_idx <= '0;
                end
                SCAN: begin
                    for (int i = 0; i < N; i++)
                        o_Grid[cell_off(br*BOX + i/BOX, bc*BOX + i%BOX, N) +: N] <= box_new[i*N +: N];
                    chg <= chg | changed;
                    box_idx <= last_box ? '0 : box_idx + BW'(1);
                    if (last_box && o_Sweeps != SW'(MAX_SWEEPS))
                        o_Sweeps <= o_Sweeps + SW'(1);
                end
                CHECK: if (term) o_Status <= res; else chg <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku_sweep_engine.sv
// tb_sudoku_sweep_engine: randomized and directed runs checked against a sweep-level model of the elimination rules.
module tb_sudoku_sweep_engine;
    localparam int B = 3;
    localparam int N = 9;
    localparam int W = N * N * N;
    typedef logic [N-1:0] m_t;

    logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic [W-1:0] grid_in = '0;
    logic busy0, done0, busy1, done1;
    logic [1:0] st0, st1;
    logic [5:0] sw0;
    logic [0:0] sw1;
    logic [W-1:0] g0, g1;
    bit selv = 1'b0;
    m_t g [N][N];
    m_t base [N][N];
    int checks = 0, failures = 0;

    wire cur_busy = selv ? busy1 : busy0;
    wire cur_done = selv ? done1 : done0;
    wire [1:0] cur_st = selv ? st1 : st0;
    wire [5:0] cur_sw = selv ? {5'd0, sw1} : sw0;
    wire [W-1:0] cur_g = selv ? g1 : g0;

    always #5 clk = ~clk;

    sudoku_sweep_engine #(.BOX(3), .MAX_SWEEPS(32)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start0), .i_Grid(grid_in),
        .o_Busy(busy0), .o_Done(done0), .o_Status(st0), .o_Sweeps(sw0), .o_Grid(g0));
    sudoku_sweep_engine #(.BOX(3), .MAX_SWEEPS(1)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start1), .i_Grid(grid_in),
        .o_Busy(busy1), .o_Done(done1), .o_Status(st1), .o_Sweeps(sw1), .o_Grid(g1));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack();
        logic [W-1:0] v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[(r*N + c)*N +: N] = g[r][c];
        return v;
    endfunction

    task automatic fill(input m_t m);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[r][c] = m;
    endtask

    // Full sweeps of box-ordered elimination; each box sees the grid as left by earlier boxes.
    task automatic model_run(input int max_sw, output int st, output int sw);
        m_t snap [N][N];
        m_t peers;
        bit chg, zero, all1;
        int r, c, rr, cc;
        sw = 0;
        for (int s = 1; s <= max_sw; s++) begin
            chg = 0;
            for (int b = 0; b < N; b++) begin
                snap = g;
                for (int i = 0; i < N; i++) begin
                    r = (b / B) * B + i / B;
                    c = (b % B) * B + i % B;
                    peers = '0;
                    for (int j = 0; j < N; j++) begin
                        rr = (r / B) * B + j / B;
                        cc = (c / B) * B + j % B;
                        if (j != c && $onehot(snap[r][j])) peers |= snap[r][j];
                        if (j != r && $onehot(snap[j][c])) peers |= snap[j][c];
                        if ((rr != r || cc != c) && $onehot(snap[rr][cc])) peers |= snap[rr][cc];
                    end
                    if (!$onehot(snap[r][c]) && (snap[r][c] & ~peers) != snap[r][c]) begin
                        g[r][c] = snap[r][c] & ~peers;
                        chg = 1;
                    end
                end
            end
            sw = s;
            zero = 0;
            all1 = 1;
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++) begin
                    if (g[y][x] == '0) zero = 1;
                    if (!$onehot(g[y][x])) all1 = 0;
                end
            if (zero) begin st = 2; return; end
            if (all1) begin st = 0; return; end
            if (!chg) begin st = 1; return; end
        end
        st = 3;
    endtask

    task automatic make_solution();
        int perm [N];
        int j, t;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[r][c] = m_t'(1) << perm[(r * B + r / B + c) % N];
    endtask

    task automatic make_puzzle();
        int p;
        make_solution();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                p = $urandom_range(99, 0);
                if (p < 35) ;
                else if (p < 75) g[r][c] = g[r][c] | m_t'($urandom);
                else if (p < 98) g[r][c] = '1;
                else g[r][c] = m_t'($urandom) & ~g[r][c];
            end
    endtask

    // Drives one run and checks busy/done every cycle, then results at the done cycle and while idle.
    task automatic run(input bit sel, input bit disturb, input string nm, output int st, output int sw);
        logic [W-1:0] exp_g;
        int lat;
        selv = sel;
        grid_in = pack();
        model_run(sel ? 1 : 32, st, sw);
        exp_g = pack();
        lat = sw * (N + 1);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        grid_in = '1;
        for (int k = 0; k <= lat + 1; k++) begin
            start0 = !sel && disturb && (k == 3 || k == lat);
            start1 = sel && disturb && (k == 3 || k == lat);
            chk($sformatf("%s_busy_k%0d", nm, k), W'(cur_busy), W'(k <= lat));
            chk($sformatf("%s_done_k%0d", nm, k), W'(cur_done), W'(k == lat));
            if (k == lat) begin
                chk({nm, "_status"}, W'(cur_st), W'(st));
                chk({nm, "_sweeps"}, W'(cur_sw), W'(sw));
                chk({nm, "_grid"}, cur_g, exp_g);
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        chk({nm, "_idle_busy"}, W'(cur_busy), W'(0));
        chk({nm, "_held_status"}, W'(cur_st), W'(st));
        chk({nm, "_held_sweeps"}, W'(cur_sw), W'(sw));
        chk({nm, "_held_grid"}, cur_g, exp_g);
    endtask

    initial begin
        int st, sw, tries;
        m_t d;
        bit found;
        repeat (2) @(negedge clk);
        chk("reset_busy", W'(busy0), W'(0));
        chk("reset_done", W'(done0), W'(0));
        chk("reset_status", W'(st0), W'(0));
        chk("reset_sweeps", W'(sw0), W'(0));
        chk("reset_grid", g0, '0);
        rst = 1'b0;
        @(negedge clk);

        make_solution();
        run(0, 0, "complete", st, sw);
        chk("pin_complete_status", W'(st), W'(0));
        chk("pin_complete_sweeps", W'(sw), W'(1));

        make_solution();
        d = g[0][0];
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[r][c] = g[r][c] == d ? m_t'(9'h010) : g[r][c] == m_t'(9'h010) ? d : g[r][c];
        g[0][0] = '1;
        run(0, 0, "single", st, sw);
        chk("pin_single_status", W'(st), W'(0));
        chk("pin_single_cell", W'(g[0][0]), W'(9'h010));
        chk("dut_single_cell", W'(g0[0 +: N]), W'(9'h010));

        fill('1);
        run(0, 0, "stall", st, sw);
        chk("pin_stall_status", W'(st), W'(1));
        chk("pin_stall_sweeps", W'(sw), W'(1));

        fill('1);
        g[0][0] = 9'h001;
        g[0][1] = 9'h002;
        g[0][2] = 9'h003;
        run(0, 0, "contra", st, sw);
        chk("pin_contra_status", W'(st), W'(2));
        chk("pin_contra_cell", W'(g[0][2]), W'(0));

        fill('1);
        g[4][4] = '0;
        run(0, 0, "zero_in", st, sw);
        chk("pin_zero_status", W'(st), W'(2));
        chk("pin_zero_sweeps", W'(sw), W'(1));

        found = 0;
        tries = 0;
        while (!found && tries < 500) begin
            make_puzzle();
            base = g;
            model_run(32, st, sw);
            found = sw >= 2;
            tries++;
        end
        chk("timeout_puzzle_found", W'(found), W'(1));
        g = base;
        run(1, 0, "timeout", st, sw);
        chk("pin_timeout_status", W'(st), W'(3));
        chk("pin_timeout_sweeps", W'(sw), W'(1));

        selv = 0;
        fill('1);
        grid_in = pack();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy0), W'(0));
        chk("abort_done", W'(done0), W'(0));
        chk("abort_grid", g0, '0);
        chk("abort_sweeps", W'(sw0), W'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_k%0d", k), W'(done0), W'(0));
        end

        make_puzzle();
        base = g;
        run(0, 0, "plain", st, sw);
        g = base;
        run(0, 1, "disturbed", st, sw);

        for (int t = 0; t < 25; t++) begin
            make_puzzle();
            run(bit'($urandom_range(3, 0) == 0), bit'($urandom_range(1, 0)), $sformatf("rand%0d", t), st, sw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
